// File: rtl/seven_seg_monitor.sv
// Receive-side monitor for an active-low 7-segment bus: debounces the pattern,
// decodes it to a digit, and flags illegal codes and non-incrementing steps.
module seven_seg_monitor #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           segments,
  output logic [WIDTH-1:0]     value,
  output logic                 valid,
  output logic                 update,
  output logic                 invalid_pattern,
  output logic                 step_error,
  output logic [CNT_WIDTH-1:0] change_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam int unsigned DIGIT_LIMIT = 2 ** WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  state_t            state;
  logic [6:0]        seg_q;
  logic [6:0]        acc_pat;
  logic [STAB_W-1:0] stab_cnt;

  logic       seg_match_c;
  logic       accept_c;
  logic [3:0] dec_digit_c;
  logic       dec_code_c;
  logic       dec_blank_c;
  logic       dec_legal_c;
  logic [WIDTH-1:0] dec_value_c;
  logic [WIDTH-1:0] next_expected_c;

  // Active-low segment code to hex digit
  always_comb begin
    dec_digit_c = 4'h0;
    dec_code_c  = 1'b1;
    dec_blank_c = 1'b0;
    case (seg_q)
      7'h40: dec_digit_c = 4'h0;
      7'h79: dec_digit_c = 4'h1;
      7'h24: dec_digit_c = 4'h2;
      7'h30: dec_digit_c = 4'h3;
      7'h19: dec_digit_c = 4'h4;
      7'h12: dec_digit_c = 4'h5;
      7'h02: dec_digit_c = 4'h6;
      7'h78: dec_digit_c = 4'h7;
      7'h00: dec_digit_c = 4'h8;
      7'h10: dec_digit_c = 4'h9;
      7'h08: dec_digit_c = 4'hA;
      7'h03: dec_digit_c = 4'hB;
      7'h46: dec_digit_c = 4'hC;
      7'h21: dec_digit_c = 4'hD;
      7'h06: dec_digit_c = 4'hE;
      7'h0E: dec_digit_c = 4'hF;
      7'h7F: begin
        dec_code_c  = 1'b0;
        dec_blank_c = 1'b1;
      end
      default: dec_code_c = 1'b0;
    endcase
  end

  assign dec_legal_c     = dec_code_c && (32'(dec_digit_c) < 32'(DIGIT_LIMIT));
  assign dec_value_c     = WIDTH'(dec_digit_c);
  assign next_expected_c = value + WIDTH'(1);

  // Accept on the edge where the stability count reaches its limit
  assign seg_match_c = (segments == seg_q);
  assign accept_c    = seg_match_c && (stab_cnt == STAB_LAST) && (seg_q != acc_pat);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      seg_q           <= 7'h7F;
      acc_pat         <= 7'h7F;
      stab_cnt        <= '0;
      value           <= '0;
      valid           <= 1'b0;
      update          <= 1'b0;
      invalid_pattern <= 1'b0;
      step_error      <= 1'b0;
      change_count    <= '0;
      error_count     <= '0;
    end else begin
      seg_q           <= segments;
      update          <= 1'b0;
      invalid_pattern <= 1'b0;
      step_error      <= 1'b0;

      if (!seg_match_c) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end

      if (accept_c) begin
        acc_pat <= seg_q;
        if (dec_blank_c) begin
          state <= IDLE;
          valid <= 1'b0;
        end else if (dec_legal_c) begin
          state  <= TRACK;
          value  <= dec_value_c;
          valid  <= 1'b1;
          update <= 1'b1;
          if (change_count != '1) change_count <= change_count + CNT_WIDTH'(1);
          // Only a digit following a held legal digit is step-checked
          if (state == TRACK && dec_value_c != next_expected_c) begin
            step_error <= 1'b1;
            if (error_count != '1) error_count <= error_count + CNT_WIDTH'(1);
          end
        end else begin
          state           <= FAULT;
          valid           <= 1'b0;
          invalid_pattern <= 1'b1;
          if (error_count != '1) error_count <= error_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Scoreboard bench for seven_seg_monitor: a hold-level model predicts each
// accepted pattern and its pulses, compared at the exact acceptance edge.
module tb_seven_seg_monitor;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STABLE = 3;
  localparam int unsigned CW     = 8;

  logic            clk;
  logic            reset_n;
  logic [6:0]      segments;
  logic [WIDTH-1:0] value;
  logic            valid;
  logic            update;
  logic            invalid_pattern;
  logic            step_error;
  logic [CW-1:0]   change_count;
  logic [CW-1:0]   error_count;

  seven_seg_monitor #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .segments(segments),
    .value(value),
    .valid(valid),
    .update(update),
    .invalid_pattern(invalid_pattern),
    .step_error(step_error),
    .change_count(change_count),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             upd;
    logic             inv;
    logic             step;
    logic [CW-1:0]    cc;
    logic [CW-1:0]    ec;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model state
  typedef enum int {M_IDLE, M_TRACK, M_FAULT} mstate_t;
  mstate_t          m_state;
  logic [6:0]       m_acc;
  logic [WIDTH-1:0] m_value;
  logic             m_valid;
  logic [CW-1:0]    m_cc;
  logic [CW-1:0]    m_ec;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // -1 illegal, 16 blank, else digit
  function automatic int decode(input logic [6:0] p);
    if (p == 7'h7F) return 16;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return (i < (1 << WIDTH)) ? i : -1;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_acc = 7'h7F; m_value = '0; m_valid = 1'b0; m_cc = '0; m_ec = '0;
    exp_q.delete();
  endtask

  // Hold pattern p for n edges (different from the previous pattern); check every cycle
  task automatic hold(input logic [6:0] p, input int n);
    bit   acc;
    int   d;
    exp_t e;
    acc = (n >= STABLE + 1) && (p != m_acc);
    if (acc) begin
      m_acc = p;
      d = decode(p);
      e.upd = 1'b0; e.inv = 1'b0; e.step = 1'b0;
      if (d == 16) begin
        m_state = M_IDLE; m_valid = 1'b0;
      end else if (d < 0) begin
        m_state = M_FAULT; m_valid = 1'b0; e.inv = 1'b1;
        if (m_ec != '1) m_ec++;
      end else begin
        e.upd = 1'b1;
        if (m_state == M_TRACK && d != ((int'(m_value) + 1) % (1 << WIDTH))) begin
          e.step = 1'b1;
          if (m_ec != '1) m_ec++;
        end
        if (m_cc != '1) m_cc++;
        m_value = WIDTH'(d); m_valid = 1'b1; m_state = M_TRACK;
      end
      e.value = m_value; e.valid = m_valid; e.cc = m_cc; e.ec = m_ec;
      if (e.upd || e.inv) exp_q.push_back(e);
      else acc = 0;
    end
    segments = p;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (acc && k == int'(STABLE)) begin
        e = exp_q.pop_front();
        checks++;
        if ({update, invalid_pattern, step_error} !== {e.upd, e.inv, e.step}) begin
          errors++;
          $display("FAIL accept_pulses pat=%h got upd/inv/step=%b%b%b want %b%b%b",
                   p, update, invalid_pattern, step_error, e.upd, e.inv, e.step);
        end
        checks++;
        if (value !== e.value || valid !== e.valid || change_count !== e.cc || error_count !== e.ec) begin
          errors++;
          $display("FAIL accept_state pat=%h got v=%h vl=%b cc=%0d ec=%0d want v=%h vl=%b cc=%0d ec=%0d",
                   p, value, valid, change_count, error_count, e.value, e.valid, e.cc, e.ec);
        end
      end else begin
        checks++;
        if ({update, invalid_pattern, step_error} !== 3'b000) begin
          errors++;
          $display("FAIL idle_pulses pat=%h k=%0d got upd/inv/step=%b%b%b want 000",
                   p, k, update, invalid_pattern, step_error);
        end
      end
    end
    checks++;
    if (value !== m_value || valid !== m_valid || change_count !== m_cc || error_count !== m_ec) begin
      errors++;
      $display("FAIL hold_end pat=%h got v=%h vl=%b cc=%0d ec=%0d want v=%h vl=%b cc=%0d ec=%0d",
               p, value, valid, change_count, error_count, m_value, m_valid, m_cc, m_ec);
    end
  endtask

  task automatic apply_reset(input logic [6:0] p);
    segments = p;
    reset_n  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    checks++;
    if (value !== '0 || valid !== 1'b0 || update !== 1'b0 || invalid_pattern !== 1'b0 ||
        step_error !== 1'b0 || change_count !== '0 || error_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%h vl=%b u=%b i=%b s=%b cc=%0d ec=%0d want all 0",
               value, valid, update, invalid_pattern, step_error, change_count, error_count);
    end
  endtask

  task automatic test_reset();
    apply_reset(7'h7F);
    hold(7'h7F, 5);
    hold(7'h40, 6);
  endtask

  task automatic test_count_up();
    hold(7'h79, 6);
    hold(7'h24, 6);
    hold(7'h30, 6);
    checks++;
    if (change_count !== 8'd4 || error_count !== 8'd0) begin
      errors++;
      $display("FAIL count_up got cc=%0d ec=%0d want cc=4 ec=0", change_count, error_count);
    end
  endtask

  task automatic test_step_error();
    hold(7'h12, 6);
    checks++;
    if (value !== 4'h5 || error_count !== 8'd1) begin
      errors++;
      $display("FAIL step_error got v=%h ec=%0d want v=5 ec=1", value, error_count);
    end
  endtask

  task automatic test_glitch();
    hold(7'h19, 2);
    hold(7'h12, 6);
    hold(7'h19, 3);
    hold(7'h12, 6);
    checks++;
    if (value !== 4'h5 || change_count !== 8'd5 || error_count !== 8'd1) begin
      errors++;
      $display("FAIL glitch got v=%h cc=%0d ec=%0d want v=5 cc=5 ec=1", value, change_count, error_count);
    end
  endtask

  task automatic test_illegal();
    hold(7'h7E, 5);
    checks++;
    if (valid !== 1'b0 || value !== 4'h5 || error_count !== 8'd2) begin
      errors++;
      $display("FAIL illegal got vl=%b v=%h ec=%0d want vl=0 v=5 ec=2", valid, value, error_count);
    end
    hold(7'h02, 6);
  endtask

  task automatic test_blank();
    hold(7'h7F, 5);
    hold(7'h46, 6);
    hold(7'h21, 6);
  endtask

  task automatic test_wrap_and_reset();
    for (int i = 6; i < 16; i++) hold(seg_tab[i], 4);
    hold(7'h40, 5);
    checks++;
    if (value !== 4'h0 || step_error !== 1'b0) begin
      errors++;
      $display("FAIL wrap got v=%h se=%b want v=0 se=0", value, step_error);
    end
    hold(7'h79, 2);
    apply_reset(7'h79);
    hold(7'h79, 6);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) hold(seg_tab[(i * 3) % 16], STABLE + 1);
  endtask

  task automatic test_saturation();
    apply_reset(7'h7F);
    for (int i = 0; i < 262; i++) hold((i % 2 == 0) ? 7'h40 : 7'h12, STABLE + 1);
    checks++;
    if (change_count !== 8'hFF || error_count !== 8'hFF) begin
      errors++;
      $display("FAIL saturation got cc=%0d ec=%0d want 255 255", change_count, error_count);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    segments = 7'h7F;
    model_reset();
    @(negedge clk);
    test_reset();
    test_count_up();
    test_step_error();
    test_glitch();
    test_illegal();
    test_blank();
    test_wrap_and_reset();
    test_back_to_back();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
